intersection_controller: RTL and testbench
==========================================

INTERSECTION_CONTROLLER -- requirements
Module: intersection_controller

Interface
REQ-001 SHALL have parameter NUM_PHASES, default 4, meaning number of conflicting signal phases (2..8).
REQ-002 SHALL have parameter TIMER_W, default 8, meaning width of the dwell timer.
REQ-003 SHALL have parameters GREEN_MIN (default 10), GREEN_MAX (default 30), YELLOW_CYC (default 5) and ALLRED_CYC (default 2), each a duration in clk cycles.
REQ-004 SHALL have port clk  input  1  system clock; all state changes occur on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port req  input  NUM_PHASES  per-phase vehicle demand (level or pulse).
REQ-007 SHALL have ports red, yellow, green  output  NUM_PHASES each  per-phase lamp drives.
REQ-008 SHALL have port cur_phase  output  $clog2(NUM_PHASES)  phase being served or last served.
REQ-009 SHALL have port cur_state  output  2  controller state encoding.

Function
REQ-010 SHALL implement states GREEN=2'b00, YELLOW=2'b01, ALLRED=2'b10; 2'b11 SHALL recover to ALLRED on the next cycle.
REQ-011 SHALL keep a dwell timer that is 0 in the first cycle of each state and increments by 1 per cycle otherwise.
REQ-012 SHALL latch demand[i] on any cycle req[i]=1; demand[i] SHALL clear in the cycle phase i enters GREEN, and clear SHALL win over a simultaneous set for that phase.
REQ-013 ALLRED SHALL last exactly ALLRED_CYC cycles; it SHALL then enter GREEN on the first phase with demand, searching round-robin from cur_phase+1; with no demand it SHALL select cur_phase+1 mod NUM_PHASES.
REQ-014 GREEN SHALL last at least GREEN_MIN and at most GREEN_MAX cycles.
REQ-015 GREEN SHALL end at the first cycle with timer>=GREEN_MIN-1 where req[cur_phase]=0 and another phase has demand (gap-out), or at timer==GREEN_MAX-1 (max-out).
REQ-016 YELLOW SHALL last exactly YELLOW_CYC cycles, then go to ALLRED.
REQ-017 Lamp outputs SHALL be decoded from registered state only.
REQ-018 In GREEN or YELLOW, only cur_phase SHALL show green or yellow; every other phase SHALL show red.
REQ-019 In ALLRED, every phase SHALL show red.
REQ-020 Each phase SHALL have exactly one lamp asserted at all times.
REQ-021 Index wrap (NUM_PHASES-1 -> 0) SHALL be handled for non-power-of-two NUM_PHASES.
REQ-022 Timer SHALL never exceed GREEN_MAX-1; no overflow is permitted.

Reset
REQ-023 While reset_n=0: state=ALLRED, timer=0, demand=0, cur_phase=NUM_PHASES-1, red=all ones, yellow=0, green=0.
REQ-024 Reset assertion mid-GREEN or mid-YELLOW SHALL force all-red immediately, without waiting for a clock.
REQ-025 After reset release, the first ALLRED SHALL last the full ALLRED_CYC cycles.

Configuration
REQ-026 Macro PED_WALK_EN defined: adds input ped_req[NUM_PHASES] and output walk[NUM_PHASES], plus parameter WALK_CYC (default 6).
REQ-027 With PED_WALK_EN, a pending ped demand on phase i SHALL drive walk[i]=1 for the first WALK_CYC cycles of that phase's GREEN.
REQ-028 With PED_WALK_EN, a pending ped demand SHALL act as vehicle demand and SHALL raise the effective minimum green to max(GREEN_MIN, WALK_CYC).
REQ-029 Without PED_WALK_EN, the ped ports and logic SHALL be absent and behaviour SHALL equal REQ-010..022.

Structure
REQ-030 Package tlc_pkg SHALL hold the state encoding constants and default durations.
REQ-031 Round-robin next-phase selection SHALL be sub-module rr_phase_select (inputs demand, cur_phase; outputs next_phase, any_demand).
REQ-032 Elaboration SHALL fail if GREEN_MAX<GREEN_MIN, if any duration is 0, or if GREEN_MAX>=2**TIMER_W.

Verification (NUM_PHASES=4, GREEN_MIN=4, GREEN_MAX=10, YELLOW_CYC=3, ALLRED_CYC=2)
REQ-033 No req after reset release -> ALLRED 2, G0 10, Y0 3, ALLRED 2, G1 10 ... repeating every 60 cycles.
REQ-034 Single-cycle req[2] pulse in the first ALLRED cycle -> first green is phase 2; phases 0 and 1 are never green.
REQ-035 Phase 1 green with req[1]=0 and demand[3] set -> green lasts exactly 4 cycles, then next green is phase 3.
REQ-036 req[1] held high and demand[3] set -> phase 1 green lasts exactly 10 cycles.
REQ-037 reset_n driven low in cycle 2 of YELLOW -> red=4'b1111 without a clock edge, demand=0, and the full reset sequence restarts.
REQ-038 PED_WALK_EN, WALK_CYC=6, ped_req[0] pulse -> walk[0]=1 for 6 cycles from G0 start, and G0 lasts at least 6 cycles.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared state encoding and default timing for the intersection controller.
package tlc_pkg;

    localparam logic [1:0] ST_GREEN   = 2'b00;
    localparam logic [1:0] ST_YELLOW  = 2'b01;
    localparam logic [1:0] ST_ALLRED  = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;

    localparam int DEF_NUM_PHASES = 4;
    localparam int DEF_TIMER_W    = 8;
    localparam int DEF_GREEN_MIN  = 10;
    localparam int DEF_GREEN_MAX  = 30;
    localparam int DEF_YELLOW_CYC = 5;
    localparam int DEF_ALLRED_CYC = 2;
    localparam int DEF_WALK_CYC   = 6;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_phase_select.sv
// Round-robin phase picker: first phase with demand after cur_phase,
// otherwise simply the phase after cur_phase (wrapping for any NUM_PHASES).
module rr_phase_select
    import tlc_pkg::*;
#(
    parameter int NUM_PHASES = DEF_NUM_PHASES
) (
    input  logic [NUM_PHASES-1:0]         demand,
    input  logic [$clog2(NUM_PHASES)-1:0] cur_phase,
    output logic [$clog2(NUM_PHASES)-1:0] next_phase,
    output logic                          any_demand
);
    localparam int PW = $clog2(NUM_PHASES);

    logic [PW-1:0] idx_s;

    // Scan from farthest to nearest so the nearest demanding phase wins.
    always_comb begin
        idx_s      = PW'((int'(cur_phase) + 1) % NUM_PHASES);
        next_phase = idx_s;
        for (int k = NUM_PHASES; k >= 1; k--) begin
            idx_s      = PW'((int'(cur_phase) + k) % NUM_PHASES);
            next_phase = demand[idx_s] ? idx_s : next_phase;
        end
        any_demand = |demand;
    end

endmodule

// File: rtl/intersection_controller.sv
// Multi-phase intersection controller: GREEN -> YELLOW -> ALLRED with gap-out,
// max-out and round-robin demand service. Macro PED_WALK_EN adds walk support.
module intersection_controller
    import tlc_pkg::*;
#(
    parameter int NUM_PHASES = DEF_NUM_PHASES,
    parameter int TIMER_W    = DEF_TIMER_W,
    parameter int GREEN_MIN  = DEF_GREEN_MIN,
    parameter int GREEN_MAX  = DEF_GREEN_MAX,
    parameter int YELLOW_CYC = DEF_YELLOW_CYC,
    parameter int ALLRED_CYC = DEF_ALLRED_CYC
`ifdef PED_WALK_EN
    ,
    parameter int WALK_CYC   = DEF_WALK_CYC
`endif
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_PHASES-1:0]         req,
`ifdef PED_WALK_EN
    input  logic [NUM_PHASES-1:0]         ped_req,
    output logic [NUM_PHASES-1:0]         walk,
`endif
    output logic [NUM_PHASES-1:0]         red,
    output logic [NUM_PHASES-1:0]         yellow,
    output logic [NUM_PHASES-1:0]         green,
    output logic [$clog2(NUM_PHASES)-1:0] cur_phase,
    output logic [1:0]                    cur_state
);
    localparam int PW = $clog2(NUM_PHASES);

    localparam logic [TIMER_W-1:0]    T_GREEN_MIN = TIMER_W'(GREEN_MIN - 1);
    localparam logic [TIMER_W-1:0]    T_GREEN_MAX = TIMER_W'(GREEN_MAX - 1);
    localparam logic [TIMER_W-1:0]    T_YELLOW    = TIMER_W'(YELLOW_CYC - 1);
    localparam logic [TIMER_W-1:0]    T_ALLRED    = TIMER_W'(ALLRED_CYC - 1);
    localparam logic [TIMER_W-1:0]    T_ZERO      = {TIMER_W{1'b0}};
    localparam logic [TIMER_W-1:0]    T_ONE       = TIMER_W'(1);
    localparam logic [NUM_PHASES-1:0] P_ONES      = {NUM_PHASES{1'b1}};
    localparam logic [NUM_PHASES-1:0] P_ZERO      = {NUM_PHASES{1'b0}};
    localparam logic [NUM_PHASES-1:0] P_ONE       = NUM_PHASES'(1);

    if (NUM_PHASES < 2 || NUM_PHASES > 8) begin : g_bad_num_phases
        $error("NUM_PHASES must be in 2..8");
    end
    if (GREEN_MIN < 1 || GREEN_MAX < 1 || YELLOW_CYC < 1 || ALLRED_CYC < 1) begin : g_bad_zero_dur
        $error("durations must be non-zero");
    end
    if (GREEN_MAX < GREEN_MIN) begin : g_bad_green_range
        $error("GREEN_MAX must not be below GREEN_MIN");
    end
    if (longint'(GREEN_MAX) >= (longint'(1) << TIMER_W)) begin : g_bad_timer_w
        $error("GREEN_MAX does not fit in TIMER_W");
    end
    // The timer saturates at GREEN_MAX-1, so no other state may outlast green.
    if (YELLOW_CYC > GREEN_MAX || ALLRED_CYC > GREEN_MAX) begin : g_bad_short_max
        $error("YELLOW_CYC and ALLRED_CYC must not exceed GREEN_MAX");
    end

    logic [1:0]            state_q, state_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [NUM_PHASES-1:0] demand_q, demand_d;
    logic [NUM_PHASES-1:0] red_q, red_d;
    logic [NUM_PHASES-1:0] yellow_q, yellow_d;
    logic [NUM_PHASES-1:0] green_q, green_d;

    logic [NUM_PHASES-1:0] svc_demand_s;
    logic [NUM_PHASES-1:0] cur_mask_s;
    logic [NUM_PHASES-1:0] next_mask_s;
    logic [NUM_PHASES-1:0] lamp_mask_s;
    logic [PW-1:0]         rr_next_s;
    logic                  rr_any_s;
    logic                  other_demand_s;
    logic                  min_met_s;
    logic                  max_out_s;
    logic                  gap_out_s;
    logic                  enter_green_s;
    logic [TIMER_W-1:0]    min_limit_s;

`ifdef PED_WALK_EN
    if (WALK_CYC < 1 || WALK_CYC > GREEN_MAX) begin : g_bad_walk
        $error("WALK_CYC must be in 1..GREEN_MAX");
    end

    localparam logic [TIMER_W-1:0] T_WALK     = TIMER_W'(WALK_CYC);
    localparam logic [TIMER_W-1:0] T_WALK_MIN = TIMER_W'(max_int(GREEN_MIN, WALK_CYC) - 1);

    logic [NUM_PHASES-1:0] ped_demand_q, ped_demand_d;
    logic [NUM_PHASES-1:0] walk_q, walk_d;
    logic                  walk_on_q, walk_on_d;

    assign svc_demand_s = demand_q | ped_demand_q;
    assign min_limit_s  = walk_on_q ? T_WALK_MIN : T_GREEN_MIN;
`else
    assign svc_demand_s = demand_q;
    assign min_limit_s  = T_GREEN_MIN;
`endif

    rr_phase_select #(
        .NUM_PHASES (NUM_PHASES)
    ) u_rr (
        .demand     (svc_demand_s),
        .cur_phase  (phase_q),
        .next_phase (rr_next_s),
        .any_demand (rr_any_s)
    );

    // Green termination qualifiers for the phase currently served.
    always_comb begin
        cur_mask_s     = P_ONE << phase_q;
        other_demand_s = rr_any_s & (|(svc_demand_s & ~cur_mask_s));
        max_out_s      = (timer_q >= T_GREEN_MAX);
        min_met_s      = (timer_q >= min_limit_s);
        gap_out_s      = min_met_s & ~req[phase_q] & other_demand_s;
    end

    // Next state, served phase, dwell timer and vehicle demand latch.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        enter_green_s = 1'b0;
        case (state_q)
            ST_GREEN: begin
                if (max_out_s || gap_out_s) begin
                    state_d = ST_YELLOW;
                end else begin
                    state_d = ST_GREEN;
                end
            end
            ST_YELLOW: begin
                if (timer_q >= T_YELLOW) begin
                    state_d = ST_ALLRED;
                end else begin
                    state_d = ST_YELLOW;
                end
            end
            ST_ALLRED: begin
                if (timer_q >= T_ALLRED) begin
                    state_d       = ST_GREEN;
                    phase_d       = rr_next_s;
                    enter_green_s = 1'b1;
                end else begin
                    state_d = ST_ALLRED;
                end
            end
            ST_ILLEGAL: state_d = ST_ALLRED;
            default:    state_d = ST_ALLRED;
        endcase

        // Clearing the phase entering green takes priority over a new request.
        next_mask_s = enter_green_s ? (P_ONE << rr_next_s) : P_ZERO;
        demand_d    = (demand_q | req) & ~next_mask_s;

        if (state_d != state_q) begin
            timer_d = T_ZERO;
        end else if (timer_q >= T_GREEN_MAX) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + T_ONE;
        end
    end

    // Lamp drives for the upcoming state, so the lamp flops track state_q exactly.
    always_comb begin
        lamp_mask_s = P_ONE << phase_d;
        case (state_d)
            ST_GREEN: begin
                green_d  = lamp_mask_s;
                yellow_d = P_ZERO;
                red_d    = ~lamp_mask_s;
            end
            ST_YELLOW: begin
                green_d  = P_ZERO;
                yellow_d = lamp_mask_s;
                red_d    = ~lamp_mask_s;
            end
            default: begin
                green_d  = P_ZERO;
                yellow_d = P_ZERO;
                red_d    = P_ONES;
            end
        endcase
    end

`ifdef PED_WALK_EN
    // Pedestrian demand latch and the walk window at the start of green.
    always_comb begin
        ped_demand_d = (ped_demand_q | ped_req) & ~next_mask_s;
        if (enter_green_s) begin
            walk_on_d = |((ped_demand_q | ped_req) & next_mask_s);
        end else if (state_d == ST_GREEN) begin
            walk_on_d = walk_on_q;
        end else begin
            walk_on_d = 1'b0;
        end
        if (walk_on_d && (state_d == ST_GREEN) && (timer_d < T_WALK)) begin
            walk_d = lamp_mask_s;
        end else begin
            walk_d = P_ZERO;
        end
    end

    // Pedestrian registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ped_demand_q <= P_ZERO;
            walk_on_q    <= 1'b0;
            walk_q       <= P_ZERO;
        end else begin
            ped_demand_q <= ped_demand_d;
            walk_on_q    <= walk_on_d;
            walk_q       <= walk_d;
        end
    end

    assign walk = walk_q;
`endif

    // Controller registers; reset parks in all-red with the last phase as "served".
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_ALLRED;
            timer_q  <= T_ZERO;
            phase_q  <= PW'(NUM_PHASES - 1);
            demand_q <= P_ZERO;
            red_q    <= P_ONES;
            yellow_q <= P_ZERO;
            green_q  <= P_ZERO;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            phase_q  <= phase_d;
            demand_q <= demand_d;
            red_q    <= red_d;
            yellow_q <= yellow_d;
            green_q  <= green_d;
        end
    end

    assign red       = red_q;
    assign yellow    = yellow_q;
    assign green     = green_q;
    assign cur_phase = phase_q;
    assign cur_state = state_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Directed and random bench for intersection_controller against a behavioural
// model of the phase/lamp rules (4 phases, green 4..10, yellow 3, all-red 2).
module tb_intersection_controller;

    localparam int NP   = 4;
    localparam int GMIN = 4;
    localparam int GMAX = 10;
    localparam int YC   = 3;
    localparam int AC   = 2;

    localparam int M_GREEN  = 0;
    localparam int M_YELLOW = 1;
    localparam int M_ALLRED = 2;

    logic          clk;
    logic          reset_n;
    logic [NP-1:0] req;
    logic [NP-1:0] red;
    logic [NP-1:0] yellow;
    logic [NP-1:0] green;
    logic [1:0]    cur_phase;
    logic [1:0]    cur_state;
`ifdef PED_WALK_EN
    logic [NP-1:0] ped_req;
    logic [NP-1:0] walk;
`endif

    int total;
    int bad;

    int m_mode;
    int m_age;
    int m_ph;
    bit m_pend [NP];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    intersection_controller #(
        .NUM_PHASES (NP),
        .TIMER_W    (8),
        .GREEN_MIN  (GMIN),
        .GREEN_MAX  (GMAX),
        .YELLOW_CYC (YC),
        .ALLRED_CYC (AC)
`ifdef PED_WALK_EN
        ,
        .WALK_CYC   (6)
`endif
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
`ifdef PED_WALK_EN
        .ped_req   (ped_req),
        .walk      (walk),
`endif
        .red       (red),
        .yellow    (yellow),
        .green     (green),
        .cur_phase (cur_phase),
        .cur_state (cur_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] enc(input int mode);
        case (mode)
            M_GREEN:  return 2'b00;
            M_YELLOW: return 2'b01;
            default:  return 2'b10;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = M_ALLRED;
        m_age  = 0;
        m_ph   = NP - 1;
        for (int i = 0; i < NP; i++) m_pend[i] = 1'b0;
    endtask

    // One clock of the rules: r is the request vector seen before the edge.
    task automatic model_step(input logic [NP-1:0] r);
        bit nxt [NP];
        bit others;
        int p;
        for (int i = 0; i < NP; i++) nxt[i] = m_pend[i] | r[i];
        case (m_mode)
            M_GREEN: begin
                others = 1'b0;
                for (int i = 0; i < NP; i++) if (i != m_ph && m_pend[i]) others = 1'b1;
                if (m_age == GMAX - 1 || (m_age >= GMIN - 1 && !r[m_ph] && others)) begin
                    m_mode = M_YELLOW;
                    m_age  = 0;
                end else m_age++;
            end
            M_YELLOW: begin
                if (m_age == YC - 1) begin
                    m_mode = M_ALLRED;
                    m_age  = 0;
                end else m_age++;
            end
            default: begin
                if (m_age == AC - 1) begin
                    p = (m_ph + 1) % NP;
                    for (int k = NP; k >= 1; k--) if (m_pend[(m_ph + k) % NP]) p = (m_ph + k) % NP;
                    m_ph    = p;
                    nxt[p]  = 1'b0;
                    m_mode  = M_GREEN;
                    m_age   = 0;
                end else m_age++;
            end
        endcase
        for (int i = 0; i < NP; i++) m_pend[i] = nxt[i];
    endtask

    task automatic check_outputs(input string tag);
        logic [NP-1:0] eg, ey, er, lamp_ok;
        for (int i = 0; i < NP; i++) begin
            eg[i]      = (m_mode == M_GREEN) && (i == m_ph);
            ey[i]      = (m_mode == M_YELLOW) && (i == m_ph);
            er[i]      = !(eg[i] || ey[i]);
            lamp_ok[i] = ((int'(red[i]) + int'(yellow[i]) + int'(green[i])) == 1);
        end
        chk({tag, "_state"},  32'(cur_state), 32'(enc(m_mode)));
        chk({tag, "_phase"},  32'(cur_phase), 32'(m_ph));
        chk({tag, "_red"},    32'(red),       32'(er));
        chk({tag, "_yellow"}, 32'(yellow),    32'(ey));
        chk({tag, "_green"},  32'(green),     32'(eg));
        chk({tag, "_onelamp"}, 32'(lamp_ok),  32'hF);
`ifdef PED_WALK_EN
        chk({tag, "_walk"},   32'(walk),      32'h0);
`endif
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_red"},    32'(red),       32'hF);
        chk({tag, "_yellow"}, 32'(yellow),    32'h0);
        chk({tag, "_green"},  32'(green),     32'h0);
        chk({tag, "_state"},  32'(cur_state), 32'h2);
        chk({tag, "_phase"},  32'(cur_phase), 32'h3);
    endtask

    task automatic tick(input logic [NP-1:0] r, input string tag);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        check_reset(tag);
        @(posedge clk);
        #1;
        check_reset({tag, "_hold"});
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NP-1:0] r;
        int  g1;
        int  nxt;
        bit  saw01;
        bit  hit;

        total   = 0;
        bad     = 0;
        reset_n = 1'b1;
        req     = 4'b0000;
`ifdef PED_WALK_EN
        ped_req = 4'b0000;
`endif
        model_reset();
        #1 reset_n = 1'b0;
        #1 check_reset("rst0");
        @(posedge clk);
        #1 check_reset("rst0_hold");
        reset_n = 1'b1;
        model_reset();

        // idle rotation: 60-cycle period through all phases
        for (int c = 1; c <= 62; c++) begin
            tick(4'b0000, "idle");
            if (c == 2)  chk("idle_g0", 32'({cur_state, cur_phase}), 32'h0);
            if (c == 12) chk("idle_y0", 32'({cur_state, cur_phase}), 32'h4);
            if (c == 15) chk("idle_ar0", 32'({cur_state, cur_phase}), 32'h8);
            if (c == 17) chk("idle_g1", 32'({cur_state, cur_phase}), 32'h1);
            if (c == 62) chk("idle_wrap_g0", 32'({cur_state, cur_phase}), 32'h0);
        end

        // one-cycle request pulse on phase 2 during the first all-red cycle
        do_reset("rst_pulse");
        saw01 = 1'b0;
        for (int c = 1; c <= 26; c++) begin
            tick((c == 1) ? 4'b0100 : 4'b0000, "pulse");
            if (c == 2) chk("pulse_first_g2", 32'({cur_state, cur_phase}), 32'h2);
            if (cur_state == 2'b00 && cur_phase < 2'd2) saw01 = 1'b1;
        end
        chk("pulse_no_g01", 32'(saw01), 32'h0);

        // gap-out: phase 1 green without its own request, phase 3 waiting
        do_reset("rst_gap");
        g1  = 0;
        nxt = -1;
        for (int c = 1; c <= 20; c++) begin
            r = (c == 1) ? 4'b0010 : ((c == 3) ? 4'b1000 : 4'b0000);
            tick(r, "gap");
            if (cur_state == 2'b00 && cur_phase == 2'd1) g1++;
            else if (cur_state == 2'b00 && nxt < 0) nxt = int'(cur_phase);
        end
        chk("gap_len", 32'(g1), 32'd4);
        chk("gap_next", 32'(nxt), 32'd3);

        // max-out: phase 1 request held, phase 3 waiting
        do_reset("rst_hold");
        g1  = 0;
        nxt = -1;
        for (int c = 1; c <= 22; c++) begin
            r = (c == 3) ? 4'b1010 : ((c <= 13) ? 4'b0010 : 4'b0000);
            tick(r, "hold");
            if (cur_state == 2'b00 && cur_phase == 2'd1) g1++;
            else if (cur_state == 2'b00 && nxt < 0) nxt = int'(cur_phase);
        end
        chk("hold_len", 32'(g1), 32'd10);
        chk("hold_next", 32'(nxt), 32'd3);

        // asynchronous reset in the second yellow cycle, with demand pending
        do_reset("rst_async");
        hit = 1'b0;
        for (int c = 1; c <= 40 && !hit; c++) begin
            r = (m_mode == M_GREEN && m_age == 0) ? 4'b0100 : 4'b0000;
            tick(r, "pre_async");
            if (m_mode == M_YELLOW && m_age == 1) hit = 1'b1;
        end
        chk("async_reached_yellow", 32'(cur_state), 32'h1);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset("async_now");
        @(posedge clk);
        #1;
        check_reset("async_hold");
        reset_n = 1'b1;
        model_reset();
        for (int c = 1; c <= 20; c++) begin
            tick(4'b0000, "post_async");
            if (c == 1) chk("post_async_ar", 32'({cur_state, cur_phase}), 32'hB);
            if (c == 2) chk("post_async_g0", 32'({cur_state, cur_phase}), 32'h0);
        end

        // random demand traffic
        do_reset("rst_rand");
        for (int c = 1; c <= 800; c++) begin
            for (int i = 0; i < NP; i++) r[i] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) r[m_ph] = 1'b1;
            tick(r, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
